// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the bit-serial adder.
// master = requester (drives start/a/b/sub); slave = sequencer (drives results).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add/sub on one reused 1-bit adder cell, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave: start/a/b/sub in; busy/done/sum/cout/ovf out).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // The single shared adder bit: two half adders and an OR.
    logic p, g, s, h, c_next, cin_msb;

    always_comb begin
        p       = a_sr_q[0] ^ b_sr_q[0];
        g       = a_sr_q[0] & b_sr_q[0];
        s       = p ^ carry_q;
        h       = p & carry_q;
        c_next  = g | h;
        // On the last RUN cycle the carry flop holds the carry into the MSB.
        cin_msb = carry_q;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtract as A + ~B + 1: invert B, seed carry with 1.
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = c_next;
                sum_d   = {s, sum_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    cout_d  = c_next;
                    ovf_d   = cin_msb ^ c_next;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table plus hand sequences for serial_add_ctrl.
// Drives the interface master side, samples 1 time unit after each rising edge.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a bound; returns edges waited and busy-high samples.
    task automatic wait_done(output int edges, inout int busy_n);
        edges = 0;
        while (!bus.done && edges < 20) begin
            tick();
            edges++;
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb_v, input logic ts,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
        int edges;
        int busy_n;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.sub   = ts;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // Scramble inputs: only the latched copies may be used.
        bus.a     = ~ta;
        bus.b     = 8'h5A;
        bus.sub   = ~ts;
        busy_n    = bus.busy ? 1 : 0;
        wait_done(edges, busy_n);
        check({tag, "_latency"}, edges, 8);
        check({tag, "_busy_cycles"}, busy_n, 9);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ovf"}, bus.ovf, eo);
        tick();
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_held_sum"}, bus.sum, es);
    endtask

    initial begin
        int edges;
        int busy_n;
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sub   = 1'b0;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};

        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        tick();
        check("idle_no_start", bus.busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].sub, vecs[i].e_sum, vecs[i].e_cout,
                   vecs[i].e_ovf);
        end

        // Leave cout/ovf at 1 so reset clearing them is visible.
        run_op("pre_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Reset in the middle of RUN.
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        check("midrst_ovf", bus.ovf, 0);
        tick();
        check("midrst_stays_idle", bus.busy, 0);
        run_op("after_rst", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

        // start held high across two operations.
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        tick();
        bus.a  = 8'h03;
        bus.b  = 8'h04;
        busy_n = 0;
        wait_done(edges, busy_n);
        check("held1_latency", edges, 7);
        check("held1_sum", bus.sum, 8'h03);
        tick();
        check("held_gap_idle", bus.busy, 0);
        tick();
        check("held2_accept", bus.busy, 1);
        check("held2_sum_clear", bus.sum, 0);
        bus.start = 1'b0;
        wait_done(edges, busy_n);
        check("held2_latency", edges, 8);
        check("held2_sum", bus.sum, 8'h07);
        tick();

        // start pulses during RUN and DONE are ignored.
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_n    = 0;
        wait_done(edges, busy_n);
        check("pulse_latency", edges, 5);
        check("pulse_sum", bus.sum, 8'h33);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("pulse_done_ignored", bus.busy, 0);
        tick();
        check("pulse_no_extra_op", bus.busy, 0);
        check("pulse_sum_held", bus.sum, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by reusing one 1-bit adder cell (two half adders plus an OR for carry) over WIDTH clock cycles, LSB first.
- Provides a start/busy/done handshake so small-area datapaths can share one adder bit instead of a full ripple chain.
- Sits between a requesting controller and the 1-bit cell; owns operand shift registers, the carry flop, the bit counter and the result register.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse, high only in DONE.
- sum  output  WIDTH  result; held stable from DONE until the next accepted start.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock is the only clock, and reset is synchronous and active-high. On a clk edge with rst=1: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, count=0, shift regs=0. rst overrides start and any in-flight operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, latch A_sr<=a, B_sr<=(sub ? ~b : b), carry<=sub, count<=0, clear sum register, go to RUN. start=0 stays IDLE. sum/cout/ovf keep their last values until start is accepted.
- RUN, per cycle, with a0=A_sr[0], b0=B_sr[0], c=carry:
  - Half adder 1: p=a0^b0, g=a0&b0.
  - Half adder 2: s=p^c, h=p&c.
  - carry<=g|h.
  - sum register shifts right with s inserted at bit WIDTH-1.
  - A_sr and B_sr shift right with 0 fill.
  - count<=count+1.
  - When count==WIDTH-1: capture c as carry-into-MSB (cin_msb), write cout<=g|h and ovf<=cin_msb^(g|h), then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle. sum holds the final value. Return to IDLE unconditionally.
- Latency: for start sampled at edge k, RUN spans edges k+1..k+WIDTH and done is high in the cycle after edge k+WIDTH. Total start-to-done is WIDTH+1 cycles. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start asserted in RUN or DONE is ignored; it is not queued. A held-high start is accepted again on the first IDLE edge.
- a, b and sub may change freely after acceptance; only the latched copies are used.
- Arithmetic is modulo 2^WIDTH. The count register is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1 in RUN.

Test Plan:
- Reset during RUN (start a=8'hFF, b=8'h01, rst pulse at cycle 3) -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. A subsequent start then runs normally.
- WIDTH=8, a=8'h35, b=8'h4A, sub=0 -> done exactly 9 cycles after the start edge, sum=8'h7F, cout=0, ovf=0, busy high for 9 cycles.
- a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0. a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Subtract: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0 (borrow), ovf=0. a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- start held high continuously across two ops (a=8'h01, b=8'h02, then the inputs change to 8'h03, 8'h04 during RUN) -> first done gives 8'h03. The second op is accepted on the IDLE edge with the new inputs and gives 8'h07. start pulses during RUN/DONE produce no extra op.
